// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared widths, ALU opcode names and controller FSM states for alu_arbiter.
package alu_ctrl_pkg;
    localparam int DATA_W = 8;
    localparam int OP_W   = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_ADDA, OP_MULA, OP_MAC, OP_ROL,
        OP_ROR, OP_AND, OP_OR, OP_XOR, OP_NAND, OP_ETH, OP_GTH, OP_LTH
    } alu_op_e;

    typedef enum logic [2:0] {IDLE, ISSUE, CAPTURE, RESP, CLR} state_e;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester handshakes, shared result bus and ALU drive of alu_arbiter.
interface alu_arbiter_if;
    import alu_ctrl_pkg::*;
    logic              req0_valid, req1_valid, req0_ready, req1_ready;
    logic              req0_lock, req1_lock, rsp0_valid, rsp1_valid, owner, locked;
    logic [OP_W-1:0]   req0_opcode, req1_opcode, alu_opcode;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b, rsp_data, alu_a, alu_b, alu_out;

    modport master (
        output req0_valid, req0_opcode, req0_a, req0_b, req0_lock,
        output req1_valid, req1_opcode, req1_a, req1_b, req1_lock, alu_out,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        input  owner, locked, alu_opcode, alu_a, alu_b
    );

    modport slave (
        input  req0_valid, req0_opcode, req0_a, req0_b, req0_lock,
        input  req1_valid, req1_opcode, req1_a, req1_b, req1_lock, alu_out,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        output owner, locked, alu_opcode, alu_a, alu_b
    );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant; a held lock restricts the grant to the current owner.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       en,
    input  logic       done,
    input  logic       done_lock,
    input  logic       owner,
    output logic [1:0] gnt,
    output logic       locked
);
    logic ptr_q, ptr_d, locked_q, locked_d, pick;

    always_comb begin
        pick     = locked_q ? owner : (&valid ? ptr_q : valid[1]);
        gnt      = en && valid[pick] ? (pick ? 2'b10 : 2'b01) : 2'b00;
        ptr_d    = done && !done_lock ? ~owner : ptr_q;
        locked_d = done ? done_lock : locked_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            ptr_q    <= ptr_d;
            locked_q <= locked_d;
        end
    end

    assign locked = locked_q;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one clocked ALU between two requesters, parking it between ops.
// Define ACC_CLEAR_EN to zero the accumulator on reset release and after each lock release.
module alu_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int              ALU_LAT = 1,
    parameter logic [OP_W-1:0] PARK_OP = 4'h0
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    localparam int CW = ALU_LAT > 1 ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ALU_LAT - 1);
`ifdef ACC_CLEAR_EN
    localparam state_e RST_STATE = CLR;
`else
    localparam state_e RST_STATE = IDLE;
`endif

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, rsp_data_q, rsp_data_d;
    logic              lock_q, lock_d, owner_q, owner_d, locked, done;
    logic [1:0]        gnt;

    assign done = state_q == RESP;

    // ready must stay low while rst_n is asserted, so the grant is gated by it
    rr_arb2 u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     ({bus.req1_valid, bus.req0_valid}),
        .en        (state_q == IDLE && rst_n),
        .done      (done),
        .done_lock (lock_q),
        .owner     (owner_q),
        .gnt       (gnt),
        .locked    (locked)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        lock_d     = lock_q;
        owner_d    = owner_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            IDLE: if (|gnt) begin
                state_d = ISSUE;
                owner_d = gnt[1];
                op_d    = gnt[1] ? bus.req1_opcode : bus.req0_opcode;
                a_d     = gnt[1] ? bus.req1_a : bus.req0_a;
                b_d     = gnt[1] ? bus.req1_b : bus.req0_b;
                lock_d  = gnt[1] ? bus.req1_lock : bus.req0_lock;
            end
            ISSUE: begin
                state_d = CAPTURE;
                cnt_d   = '0;
            end
            CAPTURE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d    = RESP;
                    rsp_data_d = bus.alu_out;
                end
            end
`ifdef ACC_CLEAR_EN
            RESP: state_d = locked && !lock_q ? CLR : IDLE;
`else
            RESP: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RST_STATE;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            lock_q     <= 1'b0;
            owner_q    <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            lock_q     <= lock_d;
            owner_q    <= owner_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];
    assign bus.rsp0_valid = done && !owner_q;
    assign bus.rsp1_valid = done && owner_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.owner      = owner_q;
    assign bus.locked     = locked;
    // MULA with a zero operand is what clears the accumulator in CLR
    assign bus.alu_opcode = state_q == ISSUE ? op_q : (state_q == CLR ? OP_MULA : PARK_OP);
    assign bus.alu_a      = state_q == ISSUE ? a_q : '0;
    assign bus.alu_b      = state_q == ISSUE ? b_q : '0;
endmodule
